// File: rtl/tdm_demux8_pkg.sv
// Shared constants and state encoding for the 8-lane TDM receive demultiplexer.
package tdm_demux8_pkg;

    localparam int TDM_LANES    = 8;
    localparam int TDM_SEL_W    = 3;
    localparam int TDM_MISS_MAX = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_demux8.sv
// 1-to-8 TDM demultiplexer: aligns a slot counter to frame_sync, flywheels through
// missing syncs, and publishes each completed frame as a registered 8-bit word.
module tdm_demux8
    import tdm_demux8_pkg::*;
#(
    parameter int LANES    = TDM_LANES,
    parameter int SEL_W    = TDM_SEL_W,
    parameter int MISS_MAX = TDM_MISS_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             en,
    input  logic             frame_sync,
    output logic [LANES-1:0] dout,
    output logic [SEL_W-1:0] sel,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err
);

    localparam int MISS_W = $clog2(MISS_MAX + 1);

    state_t            state_q, state_d;
    logic [LANES-1:0]  shadow, shadow_d;
    logic [LANES-1:0]  dout_d;
    logic [SEL_W-1:0]  sel_d;
    logic [MISS_W-1:0] miss_cnt, miss_d, miss_inc;
    logic              locked_d, frame_valid_d, sync_err_d;

    assign miss_inc = miss_cnt + MISS_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shadow      <= '0;
            dout        <= '0;
            sel         <= '0;
            miss_cnt    <= '0;
            locked      <= 1'b0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow      <= shadow_d;
            dout        <= dout_d;
            sel         <= sel_d;
            miss_cnt    <= miss_d;
            locked      <= locked_d;
            frame_valid <= frame_valid_d;
            sync_err    <= sync_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow;
        dout_d        = dout;
        sel_d         = sel;
        miss_d        = miss_cnt;
        locked_d      = locked;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en && frame_sync) begin
                    shadow_d[0] = din;
                    sel_d       = SEL_W'(1);
                    locked_d    = 1'b1;
                    miss_d      = '0;
                    state_d     = RUN;
                end
            end

            RUN: begin
                if (en) begin
                    if (sel == '0) begin
                        // A frame start without sync counts as a miss; too many drops lock.
                        if (frame_sync) begin
                            shadow_d[0] = din;
                            sel_d       = SEL_W'(1);
                            miss_d      = '0;
                        end else if (miss_inc == MISS_W'(MISS_MAX)) begin
                            miss_d   = miss_inc;
                            sel_d    = '0;
                            locked_d = 1'b0;
                            state_d  = IDLE;
                        end else begin
                            shadow_d[0] = din;
                            sel_d       = SEL_W'(1);
                            miss_d      = miss_inc;
                        end
                    end else if (frame_sync) begin
                        // Sync mid-frame: drop the partial frame and realign on this sample.
                        sync_err_d  = 1'b1;
                        shadow_d[0] = din;
                        sel_d       = SEL_W'(1);
                        miss_d      = '0;
                    end else if (sel == SEL_W'(LANES - 1)) begin
                        dout_d        = {din, shadow[LANES-2:0]};
                        frame_valid_d = 1'b1;
                        sel_d         = '0;
                    end else begin
                        shadow_d[sel] = din;
                        sel_d         = sel + SEL_W'(1);
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tdm_demux8.sv
// Self-checking bench for tdm_demux8: table-driven one-hot frames, hand-written corner
// sequences, and a frame scoreboard checked whenever frame_valid pulses.
module tb_tdm_demux8;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic       en;
    logic       frame_sync;
    logic [7:0] dout;
    logic [2:0] sel;
    logic       frame_valid;
    logic       locked;
    logic       sync_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int err_pulses   = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] pattern;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[8];

    tdm_demux8 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .en         (en),
        .frame_sync (frame_sync),
        .dout       (dout),
        .sel        (sel),
        .frame_valid(frame_valid),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Present one cycle of inputs, then return 1 time unit after the sampling edge.
    task automatic applyStimulus(input logic d, input logic fs, input logic e);
        din        = d;
        frame_sync = fs;
        en         = e;
        @(posedge clk);
        #1;
    endtask

    // Send slots first..last of a pattern; optional sync on the first slot and idle gaps.
    task automatic sendSlots(input logic [7:0] pattern, input int first, input int last,
                             input logic sync_first, input int gap);
        for (int k = first; k <= last; k++) begin
            applyStimulus(pattern[k], sync_first && (k == first), 1'b1);
            if (gap > 0 && k < last) begin
                for (int g = 0; g < gap; g++) begin
                    applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b0);
                end
                checkOutput("gap_sel_hold", 32'(sel), 32'((k + 1) % 8));
            end
        end
    endtask

    // Scoreboard: every frame_valid must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sync_err) err_pulses++;
            if (frame_valid && sync_err) checkOutput("fv_err_exclusive", 32'd1, 32'd0);
            if (frame_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_frame_valid", 32'(dout), 32'hFFFF_FFFF);
                end else begin
                    checkOutput("scoreboard_dout", 32'(dout), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        vecs[0] = '{8'h01, 8'h01};
        vecs[1] = '{8'h02, 8'h02};
        vecs[2] = '{8'h04, 8'h04};
        vecs[3] = '{8'h08, 8'h08};
        vecs[4] = '{8'h10, 8'h10};
        vecs[5] = '{8'h20, 8'h20};
        vecs[6] = '{8'h40, 8'h40};
        vecs[7] = '{8'h80, 8'h80};

        rst_n      = 1'b0;
        din        = 1'b0;
        en         = 1'b0;
        frame_sync = 1'b0;

        // Reset held with toggling data and sync
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'(i), 1'b1, 1'b1);
            checkOutput("reset_dout", 32'(dout), 32'h00);
            checkOutput("reset_sel", 32'(sel), 32'd0);
            checkOutput("reset_locked", 32'(locked), 32'd0);
            checkOutput("reset_fv", 32'(frame_valid), 32'd0);
        end
        rst_n = 1'b1;

        // One-hot frames from the vector table
        for (int v = 0; v < 8; v++) begin
            exp_q.push_back(vecs[v].exp_dout);
            sendSlots(vecs[v].pattern, 0, 7, 1'b1, 0);
            checkOutput("onehot_dout", 32'(dout), 32'(vecs[v].exp_dout));
            checkOutput("onehot_fv", 32'(frame_valid), 32'd1);
            checkOutput("onehot_locked", 32'(locked), 32'd1);
            checkOutput("onehot_sel_wrap", 32'(sel), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("fv_one_cycle", 32'(frame_valid), 32'd0);

        // Gapped enable
        exp_q.push_back(8'hA5);
        sendSlots(8'hA5, 0, 7, 1'b1, 2);
        checkOutput("gapped_dout", 32'(dout), 32'hA5);
        checkOutput("gapped_fv", 32'(frame_valid), 32'd1);

        // Mid-frame sync at sel=4, then realigned frame 3C
        sendSlots(8'hFF, 0, 3, 1'b1, 0);
        checkOutput("midsync_sel_before", 32'(sel), 32'd4);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("midsync_err", 32'(sync_err), 32'd1);
        checkOutput("midsync_no_fv", 32'(frame_valid), 32'd0);
        checkOutput("midsync_sel", 32'(sel), 32'd1);
        checkOutput("midsync_dout_kept", 32'(dout), 32'hA5);
        exp_q.push_back(8'h3C);
        sendSlots(8'h3C, 1, 7, 1'b0, 0);
        checkOutput("realign_dout", 32'(dout), 32'h3C);
        checkOutput("realign_locked", 32'(locked), 32'd1);

        // Flywheel: two syncless frames delivered, third start drops lock
        exp_q.push_back(8'h11);
        sendSlots(8'h11, 0, 7, 1'b0, 0);
        exp_q.push_back(8'h22);
        sendSlots(8'h22, 0, 7, 1'b0, 0);
        checkOutput("flywheel_dout", 32'(dout), 32'h22);
        checkOutput("flywheel_locked", 32'(locked), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("lockloss_locked", 32'(locked), 32'd0);
        checkOutput("lockloss_sel", 32'(sel), 32'd0);
        sendSlots(8'h5A, 0, 7, 1'b0, 0);
        checkOutput("idle_sel", 32'(sel), 32'd0);
        checkOutput("idle_locked", 32'(locked), 32'd0);
        checkOutput("idle_dout", 32'(dout), 32'h22);

        // Reacquire with FF
        exp_q.push_back(8'hFF);
        sendSlots(8'hFF, 0, 7, 1'b1, 0);
        checkOutput("reacq_locked", 32'(locked), 32'd1);
        checkOutput("reacq_dout", 32'(dout), 32'hFF);
        checkOutput("reacq_fv", 32'(frame_valid), 32'd1);

        // Asynchronous reset mid-frame, mid-cycle
        sendSlots(8'h0F, 0, 2, 1'b1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_dout", 32'(dout), 32'h00);
        checkOutput("async_rst_sel", 32'(sel), 32'd0);
        checkOutput("async_rst_locked", 32'(locked), 32'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Post-reset frame confirms recovery
        exp_q.push_back(8'hC3);
        sendSlots(8'hC3, 0, 7, 1'b1, 0);
        checkOutput("post_reset_dout", 32'(dout), 32'hC3);
        applyStimulus(1'b0, 1'b0, 1'b0);

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("sync_err_pulses", 32'(err_pulses), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
